traffic_phase_ctrl: RTL and testbench
=====================================

TRAFFIC_PHASE_CTRL -- requirements
Module: traffic_phase_ctrl

Interface
REQ-001 SHALL have parameter NUM_DIR, default 4, number of approach directions, legal range 2..8.
REQ-002 SHALL have parameter CNT_W, default 4, width of the tick counter.
REQ-003 SHALL have parameters GREEN_TICKS=5, YELLOW_TICKS=2, ALLRED_TICKS=1 and WALK_TICKS=3, each a phase duration in ticks, each at least 1 and at most 2^CNT_W.
REQ-004 SHALL have port clk, input, 1 bit, clock (rising edge).
REQ-005 SHALL have port rst, input, 1 bit, reset, synchronous, active-high.
REQ-006 SHALL have port tick, input, 1 bit, one-cycle timebase pulse.
REQ-007 SHALL have port ped_req, input, 1 bit, pedestrian request (pulse or level).
REQ-008 SHALL have port emerg, input, 1 bit, emergency preempt (level).
REQ-009 SHALL have port emerg_dir, input, $clog2(NUM_DIR) bits, direction to preempt to.
REQ-010 SHALL have ports green, yellow and red, each output, NUM_DIR bits, per-direction lamps.
REQ-011 SHALL have port walk, output, 1 bit, pedestrian walk lamp.
REQ-012 SHALL have port cur_dir, output, $clog2(NUM_DIR) bits, current served direction.

Function
REQ-013 SHALL implement FSM states GREEN, YELLOW, ALLRED, WALK and a direction register dir.
REQ-014 SHALL advance the phase counter only on clock edges where tick=1: if count==DUR-1, transition and clear count to 0; else increment count; each phase therefore lasts exactly DUR ticks.
REQ-015 SHALL follow the normal sequence GREEN(d) -> YELLOW(d) -> ALLRED.
REQ-016 SHALL choose the ALLRED exit by priority: emergency -> GREEN(emerg_dir); else ped_pending -> WALK; else GREEN((d+1) mod NUM_DIR).
REQ-017 SHALL go from WALK to GREEN((d+1) mod NUM_DIR).
REQ-018 SHALL drive outputs registered and Moore-decoded from the state: in GREEN/YELLOW, bit dir of green/yellow is 1 and all other bits of red are 1; in ALLRED/WALK, red is all ones; walk=1 only in WALK.
REQ-019 SHALL keep exactly one of green[i], yellow[i], red[i] high for every i in every cycle.
REQ-020 SHALL set ped_pending on any cycle with ped_req=1 and clear it on entry to WALK; a ped_req in the same cycle as WALK entry SHALL be dropped.
REQ-021 SHALL treat emergency as valid only when emerg=1 and emerg_dir<NUM_DIR; out-of-range values SHALL be ignored.
REQ-022 SHALL freeze count in GREEN(d) with d==emerg_dir while the emergency is valid; green is held indefinitely and counting resumes from the frozen value after release.
REQ-023 SHALL, in GREEN(d) with d!=emerg_dir and the emergency valid, move to YELLOW(d) on the next clk edge with count=0, regardless of tick.
REQ-024 SHALL, in WALK with the emergency valid, move to ALLRED on the next edge with count=0, walk deasserted and ped_pending re-set.
REQ-025 SHALL never shorten YELLOW or ALLRED.
REQ-026 SHALL evaluate a tick coinciding with a preempt (REQ-023/024) as the preempt only, not also as a count.
REQ-027 SHALL make cur_dir equal dir in every state.

Reset
REQ-028 SHALL, on rst=1 at a clk edge, set state=GREEN, dir=0, count=0 and ped_pending=0, giving green=1, yellow=0, red=~1 (all bits except bit 0), walk=0 and cur_dir=0 the following cycle.
REQ-029 SHALL take rst precedence over tick, ped_req and emerg; reset mid-phase SHALL abort immediately.

Structure
REQ-030 SHALL take the state enumeration and phase-duration defaults from shared package traffic_pkg.
REQ-031 SHALL place the tick-gated phase counter (load, freeze, done at DUR-1) in sub-module tick_timer.

Verification
(Defaults, tick every 4 clk cycles.)
REQ-032 Reset then free-run 3 full rotations -> dir order 0,1,2,3,0; each GREEN spans 5 ticks, YELLOW 2, ALLRED 1; lamp exclusivity asserted every cycle.
REQ-033 ped_req pulse during GREEN(1) -> after ALLRED, WALK for 3 ticks, red=4'b1111, walk=1; then GREEN(2); ped_pending=0.
REQ-034 emerg=1, emerg_dir=2 during GREEN(0) at count 1 -> YELLOW(0) next edge, ALLRED, GREEN(2) held 40 ticks; release -> GREEN(2) completes remaining ticks, then GREEN(3).
REQ-035 emerg_dir=2 asserted during WALK -> ALLRED next edge, walk=0, then GREEN(2); the WALK is served after the emergency ends.
REQ-036 rst asserted mid-YELLOW(3), plus NUM_DIR=2 rerun and emerg_dir=3 with NUM_DIR=3 -> reset state per REQ-028; the 2-direction rotation alternates 0,1; the out-of-range emergency is ignored.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic phase controller: phase enumeration and
// default phase durations (in ticks).
package traffic_pkg;

  typedef enum logic [1:0] {
    GREEN  = 2'd0,
    YELLOW = 2'd1,
    ALLRED = 2'd2,
    WALK   = 2'd3
  } phase_t;

  localparam int unsigned DEF_NUM_DIR      = 4;
  localparam int unsigned DEF_CNT_W        = 4;
  localparam int unsigned DEF_GREEN_TICKS  = 5;
  localparam int unsigned DEF_YELLOW_TICKS = 2;
  localparam int unsigned DEF_ALLRED_TICKS = 1;
  localparam int unsigned DEF_WALK_TICKS   = 3;

endpackage

// File: rtl/tick_timer.sv
// Tick-gated phase counter: counts ticks up to 'last', wraps to 0 on the
// final tick (signalled by done), can be cleared or frozen.
module tick_timer #(
  parameter int unsigned CNT_W = traffic_pkg::DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             clear,
  input  logic             freeze,
  input  logic [CNT_W-1:0] last,
  output logic             done
);

  logic [CNT_W-1:0] count;

  assign done = tick && !freeze && (count == last);

  // Clear wins over counting so a preempt edge never doubles as a count.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (tick && !freeze) begin
      count <= done ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Traffic phase controller: rotates green through NUM_DIR approaches with
// yellow and all-red clearance, serves pedestrian walk requests after all-red,
// and supports emergency preemption toward a selected direction.
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int unsigned NUM_DIR      = DEF_NUM_DIR,
  parameter int unsigned CNT_W        = DEF_CNT_W,
  parameter int unsigned GREEN_TICKS  = DEF_GREEN_TICKS,
  parameter int unsigned YELLOW_TICKS = DEF_YELLOW_TICKS,
  parameter int unsigned ALLRED_TICKS = DEF_ALLRED_TICKS,
  parameter int unsigned WALK_TICKS   = DEF_WALK_TICKS,
  localparam int unsigned DIR_W       = $clog2(NUM_DIR)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               ped_req,
  input  logic               emerg,
  input  logic [DIR_W-1:0]   emerg_dir,
  output logic [NUM_DIR-1:0] green,
  output logic [NUM_DIR-1:0] yellow,
  output logic [NUM_DIR-1:0] red,
  output logic               walk,
  output logic [DIR_W-1:0]   cur_dir
);

  localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_TICKS - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_TICKS - 1);
  localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_TICKS - 1);
  localparam logic [CNT_W-1:0] WALK_LAST   = CNT_W'(WALK_TICKS - 1);
  localparam logic [DIR_W-1:0] DIR_MAX     = DIR_W'(NUM_DIR - 1);

  phase_t             state, nxt_state;
  logic [DIR_W-1:0]   dir, nxt_dir, dir_inc;
  logic               ped_pending, nxt_ped;
  logic               emerg_ok;
  logic               tmr_clear, tmr_freeze, tmr_done;
  logic [CNT_W-1:0]   tmr_last;
  logic [NUM_DIR-1:0] nxt_mask;

  // Emergency only counts when it names an existing direction.
  if (NUM_DIR == (1 << DIR_W)) begin : g_full_range
    assign emerg_ok = emerg;
  end else begin : g_part_range
    assign emerg_ok = emerg && (emerg_dir < DIR_W'(NUM_DIR));
  end

  assign dir_inc    = (dir == DIR_MAX) ? '0 : dir + 1'b1;
  assign tmr_freeze = (state == GREEN) && emerg_ok && (dir == emerg_dir);
  assign cur_dir    = dir;
  assign nxt_mask   = NUM_DIR'(1) << nxt_dir;

  // Phase duration for the counter, selected by the current phase.
  always_comb begin
    tmr_last = GREEN_LAST;
    case (state)
      GREEN:  tmr_last = GREEN_LAST;
      YELLOW: tmr_last = YELLOW_LAST;
      ALLRED: tmr_last = ALLRED_LAST;
      WALK:   tmr_last = WALK_LAST;
      default: tmr_last = GREEN_LAST;
    endcase
  end

  tick_timer #(.CNT_W(CNT_W)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .tick   (tick),
    .clear  (tmr_clear),
    .freeze (tmr_freeze),
    .last   (tmr_last),
    .done   (tmr_done)
  );

  // Next phase, direction and pedestrian-pending decisions.
  always_comb begin
    nxt_state = state;
    nxt_dir   = dir;
    nxt_ped   = ped_pending | ped_req;
    tmr_clear = 1'b0;
    case (state)
      GREEN: begin
        if (emerg_ok && (dir != emerg_dir)) begin
          nxt_state = YELLOW;
          tmr_clear = 1'b1;
        end else if (tmr_done) begin
          nxt_state = YELLOW;
        end
      end
      YELLOW: begin
        if (tmr_done) nxt_state = ALLRED;
      end
      ALLRED: begin
        if (tmr_done) begin
          if (emerg_ok) begin
            nxt_state = GREEN;
            nxt_dir   = emerg_dir;
          end else if (ped_pending) begin
            nxt_state = WALK;
            nxt_ped   = 1'b0;
          end else begin
            nxt_state = GREEN;
            nxt_dir   = dir_inc;
          end
        end
      end
      WALK: begin
        // An interrupted walk is re-queued so it is served after the emergency.
        if (emerg_ok) begin
          nxt_state = ALLRED;
          tmr_clear = 1'b1;
          nxt_ped   = 1'b1;
        end else if (tmr_done) begin
          nxt_state = GREEN;
          nxt_dir   = dir_inc;
        end
      end
      default: nxt_state = GREEN;
    endcase
  end

  // State register with lamps decoded from the next state so they stay aligned.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= GREEN;
      dir         <= '0;
      ped_pending <= 1'b0;
      green       <= NUM_DIR'(1);
      yellow      <= '0;
      red         <= ~NUM_DIR'(1);
      walk        <= 1'b0;
    end else begin
      state       <= nxt_state;
      dir         <= nxt_dir;
      ped_pending <= nxt_ped;
      green       <= (nxt_state == GREEN)  ? nxt_mask : '0;
      yellow      <= (nxt_state == YELLOW) ? nxt_mask : '0;
      red         <= ((nxt_state == GREEN) || (nxt_state == YELLOW)) ? ~nxt_mask : '1;
      walk        <= (nxt_state == WALK);
    end
  end

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Bench for traffic_phase_ctrl: three instances (4, 2 and 3 directions) driven
// by shared directed and random stimulus, compared every cycle against a
// remaining-ticks reference model.
module tb_traffic_phase_ctrl;

  localparam int M_GREEN  = 0;
  localparam int M_YELLOW = 1;
  localparam int M_ALLRED = 2;
  localparam int M_WALK   = 3;

  typedef struct {
    int ph;
    int dir;
    int rem;
    bit ped;
  } mdl_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick = 1'b0;
  logic ped_req = 1'b0;
  logic emerg = 1'b0;
  int   ed[3];
  bit   rnd_mode = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   nd[3] = '{4, 2, 3};
  mdl_t mdl[3];

  logic [1:0] ed0;
  logic       ed1;
  logic [1:0] ed2;
  logic [3:0] g0, y0, r0;
  logic [1:0] g1, y1, r1;
  logic [2:0] g2, y2, r2;
  logic       w0, w1, w2;
  logic [1:0] d0;
  logic       d1;
  logic [1:0] d2;

  assign ed0 = ed[0][1:0];
  assign ed1 = ed[1][0];
  assign ed2 = ed[2][1:0];

  always #5 clk = ~clk;

  traffic_phase_ctrl dut0 (
    .clk(clk), .rst(rst), .tick(tick), .ped_req(ped_req), .emerg(emerg), .emerg_dir(ed0),
    .green(g0), .yellow(y0), .red(r0), .walk(w0), .cur_dir(d0)
  );

  traffic_phase_ctrl #(.NUM_DIR(2)) dut1 (
    .clk(clk), .rst(rst), .tick(tick), .ped_req(ped_req), .emerg(emerg), .emerg_dir(ed1),
    .green(g1), .yellow(y1), .red(r1), .walk(w1), .cur_dir(d1)
  );

  traffic_phase_ctrl #(.NUM_DIR(3)) dut2 (
    .clk(clk), .rst(rst), .tick(tick), .ped_req(ped_req), .emerg(emerg), .emerg_dir(ed2),
    .green(g2), .yellow(y2), .red(r2), .walk(w2), .cur_dir(d2)
  );

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d got %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.ph = M_GREEN; m.dir = 0; m.rem = 5; m.ped = 1'b0;
    return m;
  endfunction

  // One clock edge of the controller, expressed as ticks remaining in a phase.
  function automatic mdl_t mdl_step(mdl_t m, int n, bit t, bit pr, bit em, int edir);
    mdl_t r = m;
    bit valid = em && (edir < n);
    r.ped = m.ped | pr;
    case (m.ph)
      M_GREEN: begin
        if (valid && m.dir == edir) begin
          // held
        end else if (valid) begin
          r.ph = M_YELLOW; r.rem = 2;
        end else if (t) begin
          r.rem = m.rem - 1;
          if (r.rem == 0) begin r.ph = M_YELLOW; r.rem = 2; end
        end
      end
      M_YELLOW: if (t) begin
        r.rem = m.rem - 1;
        if (r.rem == 0) begin r.ph = M_ALLRED; r.rem = 1; end
      end
      M_ALLRED: if (t) begin
        r.rem = m.rem - 1;
        if (r.rem == 0) begin
          if (valid) begin r.ph = M_GREEN; r.dir = edir; r.rem = 5; end
          else if (m.ped) begin r.ph = M_WALK; r.rem = 3; r.ped = 1'b0; end
          else begin r.ph = M_GREEN; r.dir = (m.dir + 1) % n; r.rem = 5; end
        end
      end
      default: begin
        if (valid) begin
          r.ph = M_ALLRED; r.rem = 1; r.ped = 1'b1;
        end else if (t) begin
          r.rem = m.rem - 1;
          if (r.rem == 0) begin r.ph = M_GREEN; r.dir = (m.dir + 1) % n; r.rem = 5; end
        end
      end
    endcase
    return r;
  endfunction

  task automatic compare_dut(input int k);
    int og, oy, orr, ow, od, all, lit, bad;
    case (k)
      0: begin og = int'(g0); oy = int'(y0); orr = int'(r0); ow = int'(w0); od = int'(d0); end
      1: begin og = int'(g1); oy = int'(y1); orr = int'(r1); ow = int'(w1); od = int'(d1); end
      default: begin og = int'(g2); oy = int'(y2); orr = int'(r2); ow = int'(w2); od = int'(d2); end
    endcase
    all = (1 << nd[k]) - 1;
    lit = 1 << mdl[k].dir;
    check_eq($sformatf("green%0d", k), og, (mdl[k].ph == M_GREEN) ? lit : 0);
    check_eq($sformatf("yellow%0d", k), oy, (mdl[k].ph == M_YELLOW) ? lit : 0);
    check_eq($sformatf("red%0d", k), orr,
             (mdl[k].ph == M_GREEN || mdl[k].ph == M_YELLOW) ? (all & ~lit) : all);
    check_eq($sformatf("walk%0d", k), ow, (mdl[k].ph == M_WALK) ? 1 : 0);
    check_eq($sformatf("cur_dir%0d", k), od, mdl[k].dir);
    bad = 0;
    for (int i = 0; i < nd[k]; i++) begin
      if ((((og >> i) & 1) + ((oy >> i) & 1) + ((orr >> i) & 1)) != 1) bad++;
    end
    check_eq($sformatf("lamp_excl%0d", k), bad, 0);
  endtask

  task automatic cycle();
    tick = rnd_mode ? ($urandom_range(0, 2) == 0) : ((cyc % 4) == 3);
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      mdl[k] = rst ? mdl_reset() : mdl_step(mdl[k], nd[k], tick, ped_req, emerg, ed[k]);
      compare_dut(k);
    end
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    int prev_g, order_idx, guard;
    ed[0] = 0; ed[1] = 0; ed[2] = 0;

    // Reset, then three full rotations with the green-entry order tracked.
    rst = 1'b1;
    run(2);
    rst = 1'b0;
    prev_g = int'(g0);
    order_idx = 1;
    for (int i = 0; i < 3 * 32 * 4 + 8; i++) begin
      cycle();
      if (g0 != 4'd0 && prev_g == 0) begin
        check_eq("rot_order", int'(d0), order_idx % 4);
        order_idx++;
      end
      prev_g = int'(g0);
    end

    // Pedestrian pulse during GREEN(1).
    guard = 0;
    while (!(g0 == 4'b0010) && guard < 200) begin cycle(); guard++; end
    check_eq("wait_green1", (guard < 200) ? 1 : 0, 1);
    ped_req = 1'b1; cycle(); ped_req = 1'b0;
    run(80);

    // Emergency to direction 2 early in GREEN(0), held ~40 ticks, then released.
    rst = 1'b1; cycle(); rst = 1'b0;
    guard = 0;
    while (mdl[0].rem != 4 && guard < 20) begin cycle(); guard++; end
    ed[0] = 2; ed[1] = 1; ed[2] = 2; emerg = 1'b1;
    run(180);
    emerg = 1'b0;
    run(120);

    // Emergency arriving during WALK.
    ped_req = 1'b1; cycle(); ped_req = 1'b0;
    guard = 0;
    while (!w0 && guard < 400) begin cycle(); guard++; end
    check_eq("wait_walk", (guard < 400) ? 1 : 0, 1);
    emerg = 1'b1;
    run(60);
    emerg = 1'b0;
    run(120);

    // Reset in the middle of YELLOW(3).
    guard = 0;
    while (!y0[3] && guard < 600) begin cycle(); guard++; end
    check_eq("wait_yellow3", (guard < 600) ? 1 : 0, 1);
    rst = 1'b1; cycle(); rst = 1'b0;
    run(20);

    // Random traffic including out-of-range emergency directions.
    rnd_mode = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      ped_req = ($urandom_range(0, 19) == 0);
      rst     = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 39) == 0) begin
        emerg = ~emerg;
        ed[0] = $urandom_range(0, 3);
        ed[1] = $urandom_range(0, 1);
        ed[2] = $urandom_range(0, 3);
      end
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
